// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor/direction/door constants for the elevator front end
package elevator_pkg;
  localparam int NUM_FLOORS_DEFAULT = 4;
  localparam int FLOOR_W = 3;
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic DOOR_OPEN = 1'b1;
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop synchronizer, optional debounce (ELEV_DEBOUNCE_EN), rising-edge press pulse
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  logic s1, s2, lvl, lvl_q;
`ifdef ELEV_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic db;
  // db flips only after the synced level has disagreed with it for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge clk) begin
    if (reset) begin
      {s1, s2, lvl_q, db} <= '0;
      cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      lvl_q <= db;
      if (s2 == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign lvl = db;
`else
  always_ff @(posedge clk) begin
    if (reset) {s1, s2, lvl_q} <= '0;
    else begin
      s1 <= btn;
      s2 <= s1;
      lvl_q <= s2;
    end
  end
  assign lvl = s2;
`endif
  assign press = lvl & ~lvl_q;
endmodule

// File: rtl/call_request_panel.sv
// call_request_panel: latches hall/car button presses into u/d/i request flags, cleared on service; debounce via ELEV_DEBOUNCE_EN
module call_request_panel
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn_up,
  input  logic [NUM_FLOORS-1:0] btn_dn,
  input  logic [NUM_FLOORS-1:0] btn_car,
  input  logic [FLOOR_W-1:0]    F,
  input  logic [1:0]            dir,
  input  logic                  door,
  output logic [NUM_FLOORS-1:0] u,
  output logic [NUM_FLOORS-1:0] d,
  output logic [NUM_FLOORS-1:0] i,
  output logic                  req_any
);
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
  logic [NUM_FLOORS-1:0] p_up, p_dn, p_car, hit, u_nx, d_nx, i_nx;
  logic clr_up, clr_dn;
  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cu (.clk, .reset, .btn(btn_up[g]), .press(p_up[g]));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cd (.clk, .reset, .btn(btn_dn[g]), .press(p_dn[g]));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cc (.clk, .reset, .btn(btn_car[g]), .press(p_car[g]));
  end
  // clear is applied after set so a press at the serviced floor is absorbed
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_FLOORS; k++) hit[k] = (door == DOOR_OPEN) && (F == FLOOR_W'(k + 1));
    clr_up = dir == DIR_IDLE || dir == DIR_UP;
    clr_dn = dir == DIR_IDLE || dir == DIR_DOWN;
    u_nx = (u | p_up) & ~(clr_up ? hit : '0) & UP_MASK;
    d_nx = (d | p_dn) & ~(clr_dn ? hit : '0) & DN_MASK;
    i_nx = (i | p_car) & ~hit;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      u <= '0;
      d <= '0;
      i <= '0;
      req_any <= 1'b0;
    end else begin
      u <= u_nx;
      d <= d_nx;
      i <= i_nx;
      req_any <= |{u, d, i};
    end
  end
endmodule
